// File: rtl/mem0_stage.sv
// mem0_stage - first memory pipeline stage, directly downstream of execute.
//
// Latches the execute-to-mem0 bus. For loads and stores it raises one
// address-phase request toward data memory (size, byte strobes, replicated
// store data) and holds the instruction until the memory accepts the address
// and mem1 can take it. Non-memory instructions pass through in one cycle.
//
// Optional feature macro: MEM0_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses raise ale, issue no request,
//               and leave with rd_we cleared.
//   undefined : ale is tied 0 and every load/store issues a request.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   ex2mem0_bus_i[107:0]    {mem_ctl[5:0], st_data, ex_result, rd_addr, rd_we, pc}
//                           (EX2MEM0BusSize = 108 in common.vh)
//   ctl_ex_over_i           EX holds a finished instruction
//   ctl_mem0_allowin_o      mem0 can accept this cycle
//   ctl_mem1_allowin_i      mem1 can accept this cycle
//   ctl_mem0_over_o         mem0 instruction done, may advance
//   mem02mem1_bus_o[76:0]   {ale, load, size, zext, addr_lo, result, rd_addr, rd_we, pc}
//                           (MEM02MEM1BusSize = 77 in common.vh)
//   ctl_mem0_dest_o         rd_addr gated by valid
//   ctl_mem0_pc_o           latched pc
//   forward_mem02id_data_o  latched ex_result
//   data_req_o .. data_wdata_o  address-phase request to data memory
//   data_addr_ok_i          memory accepts the address this cycle

module mem0_stage (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [107:0] ex2mem0_bus_i,
    input  logic         ctl_ex_over_i,
    output logic         ctl_mem0_allowin_o,
    input  logic         ctl_mem1_allowin_i,
    output logic         ctl_mem0_over_o,
    output logic [76:0]  mem02mem1_bus_o,
    output logic [4:0]   ctl_mem0_dest_o,
    output logic [31:0]  ctl_mem0_pc_o,
    output logic [31:0]  forward_mem02id_data_o,
    output logic         data_req_o,
    output logic         data_wr_o,
    output logic [1:0]   data_size_o,
    output logic [31:0]  data_addr_o,
    output logic [3:0]   data_wstrb_o,
    output logic [31:0]  data_wdata_o,
    input  logic         data_addr_ok_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          valid_q;
    // mem_ctl bit0 carries no meaning, so only bits [5:1] are kept.
    logic [4:0]    ctl_q;
    logic [101:0]  data_q;

    logic          capture;
    logic          leave;
    logic          is_load;
    logic          is_store;
    logic [1:0]    size_n;
    logic          zext;
    logic [31:0]   st_data;
    logic [31:0]   ex_result;
    logic [4:0]    rd_addr;
    logic          rd_we;
    logic [31:0]   pc;
    logic          ale;
    logic          in_ale;
    logic          memop;
    logic          in_memop;
    logic [3:0]    strobe;
    logic [31:0]   wdata;

    assign is_load   = ctl_q[4];
    assign is_store  = ctl_q[3];
    // Size 11 is treated as a word access everywhere downstream.
    assign size_n    = (ctl_q[2:1] == 2'b11) ? 2'b10 : ctl_q[2:1];
    assign zext      = ctl_q[0];
    assign st_data   = data_q[101:70];
    assign ex_result = data_q[69:38];
    assign rd_addr   = data_q[37:33];
    assign rd_we     = data_q[32];
    assign pc        = data_q[31:0];

`ifdef MEM0_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        // size[1] covers both word encodings (10 and 11).
        return ((size == 2'b01) && lo[0]) || (size[1] && (lo != 2'b00));
    endfunction

    assign ale    = (is_load | is_store) & misaligned(ctl_q[2:1], ex_result[1:0]);
    assign in_ale = (ex2mem0_bus_i[107] | ex2mem0_bus_i[106])
                  & misaligned(ex2mem0_bus_i[105:104], ex2mem0_bus_i[39:38]);
`else
    assign ale    = 1'b0;
    assign in_ale = 1'b0;
`endif

    // A flagged misaligned access behaves like a non-memory instruction.
    assign memop    = (is_load | is_store) & ~ale;
    assign in_memop = (ex2mem0_bus_i[107] | ex2mem0_bus_i[106]) & ~in_ale;

    assign capture = ctl_ex_over_i & ctl_mem0_allowin_o;
    assign leave   = ctl_mem0_over_o & ctl_mem1_allowin_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            data_q  <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            ctl_q   <= ex2mem0_bus_i[107:103];
            data_q  <= ex2mem0_bus_i[101:0];
        end else if (leave) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new capture always decides the next state; otherwise REQ waits for
    // addr_ok and HELD waits for mem1. addr_ok outside REQ is ignored.
    always_comb begin
        state_d = state_q;
        if (capture) begin
            state_d = in_memop ? REQ : IDLE;
        end else begin
            case (state_q)
                REQ: begin
                    if (data_addr_ok_i) begin
                        state_d = ctl_mem1_allowin_i ? IDLE : HELD;
                    end
                end
                HELD: begin
                    if (ctl_mem1_allowin_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        data_req_o         = (state_q == REQ);
        ctl_mem0_over_o    = valid_q & (~memop
                                        | ((state_q == REQ) & data_addr_ok_i)
                                        | (state_q == HELD));
        ctl_mem0_allowin_o = ~valid_q | (ctl_mem0_over_o & ctl_mem1_allowin_i);
    end

    // Half strobes ignore addr[0]; a misaligned low bit is simply dropped.
    always_comb begin
        strobe = 4'b1111;
        wdata  = st_data;
        case (size_n)
            2'b00: begin
                strobe = 4'b0001 << ex_result[1:0];
                wdata  = {4{st_data[7:0]}};
            end
            2'b01: begin
                strobe = ex_result[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{st_data[15:0]}};
            end
            default: begin
                strobe = 4'b1111;
                wdata  = st_data;
            end
        endcase
    end

    assign data_wr_o              = is_store;
    assign data_size_o            = size_n;
    assign data_addr_o            = ex_result;
    assign data_wstrb_o           = is_store ? strobe : 4'b0000;
    assign data_wdata_o           = wdata;
    assign ctl_mem0_dest_o        = rd_addr & {5{valid_q}};
    assign ctl_mem0_pc_o          = pc;
    assign forward_mem02id_data_o = ex_result;
    assign mem02mem1_bus_o        = {ale, is_load, size_n, zext, ex_result[1:0],
                                     ex_result, rd_addr, rd_we & ~ale, pc};

endmodule

// File: tb/tb_mem0_stage.sv
// tb_mem0_stage - directed and randomized bench for mem0_stage.
// The reference model tracks one in-flight instruction as "valid" plus
// "address already accepted", and derives strobes and store data from the
// access byte count with plain arithmetic.

module tb_mem0_stage;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [107:0] ex2mem0_bus_i;
    logic         ctl_ex_over_i;
    logic         ctl_mem0_allowin_o;
    logic         ctl_mem1_allowin_i;
    logic         ctl_mem0_over_o;
    logic [76:0]  mem02mem1_bus_o;
    logic [4:0]   ctl_mem0_dest_o;
    logic [31:0]  ctl_mem0_pc_o;
    logic [31:0]  forward_mem02id_data_o;
    logic         data_req_o;
    logic         data_wr_o;
    logic [1:0]   data_size_o;
    logic [31:0]  data_addr_o;
    logic [3:0]   data_wstrb_o;
    logic [31:0]  data_wdata_o;
    logic         data_addr_ok_i;

    int testsRun  = 0;
    int failCount = 0;
    int cycleNum  = 0;

    // reference model state
    logic         mValid;
    logic         mAccepted;
    logic [107:0] mBus;
    logic         eOver;
    logic         eAllow;
    logic         eReq;

    mem0_stage dut (
        .clk_i                  (clk_i),
        .rst_n_i                (rst_n_i),
        .ex2mem0_bus_i          (ex2mem0_bus_i),
        .ctl_ex_over_i          (ctl_ex_over_i),
        .ctl_mem0_allowin_o     (ctl_mem0_allowin_o),
        .ctl_mem1_allowin_i     (ctl_mem1_allowin_i),
        .ctl_mem0_over_o        (ctl_mem0_over_o),
        .mem02mem1_bus_o        (mem02mem1_bus_o),
        .ctl_mem0_dest_o        (ctl_mem0_dest_o),
        .ctl_mem0_pc_o          (ctl_mem0_pc_o),
        .forward_mem02id_data_o (forward_mem02id_data_o),
        .data_req_o             (data_req_o),
        .data_wr_o              (data_wr_o),
        .data_size_o            (data_size_o),
        .data_addr_o            (data_addr_o),
        .data_wstrb_o           (data_wstrb_o),
        .data_wdata_o           (data_wdata_o),
        .data_addr_ok_i         (data_addr_ok_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                     tag, cycleNum, observed, expected);
        end
    endtask

    function automatic logic [107:0] mkBus(input logic ld, input logic st,
                                           input logic [1:0] sz, input logic zx,
                                           input logic [31:0] stData,
                                           input logic [31:0] addr,
                                           input logic [4:0] rd, input logic we,
                                           input logic [31:0] pc);
        return {ld, st, sz, zx, 1'b0, stData, addr, rd, we, pc};
    endfunction

    function automatic logic isMisaligned(input logic [107:0] b);
`ifdef MEM0_ALIGN_CHECK_EN
        int nb;
        if (!(b[107] | b[106])) return 1'b0;
        nb = (b[105:104] == 2'b00) ? 1 : (b[105:104] == 2'b01) ? 2 : 4;
        return (b[39:38] % nb) != 0;
`else
        return (b[107] & 1'b0);
`endif
    endfunction

    // Compare every DUT output against the model for the current cycle.
    task automatic checkCycle();
        logic         ld, st, zx, we, ale, memop;
        logic [1:0]   szn;
        logic [31:0]  stData, addr, pc, expWdata;
        logic [4:0]   rd;
        logic [3:0]   expStrb;
        int           nb, base;
        ld     = mBus[107];
        st     = mBus[106];
        szn    = (mBus[105:104] == 2'b11) ? 2'b10 : mBus[105:104];
        zx     = mBus[103];
        stData = mBus[101:70];
        addr   = mBus[69:38];
        rd     = mBus[37:33];
        we     = mBus[32];
        pc     = mBus[31:0];
        ale    = isMisaligned(mBus);
        memop  = (ld | st) & ~ale;

        nb   = 1 << szn;
        base = int'(addr[1:0]) - (int'(addr[1:0]) % nb);
        expStrb = st ? 4'(((1 << nb) - 1) << base) : 4'b0000;
        for (int i = 0; i < 4; i++) begin
            expWdata[8*i +: 8] = stData[8*(i % nb) +: 8];
        end

        eReq   = mValid & memop & ~mAccepted;
        eOver  = mValid & (~memop | mAccepted | (eReq & data_addr_ok_i));
        eAllow = ~mValid | (eOver & ctl_mem1_allowin_i);

        checkOutput("req",     data_req_o, eReq);
        checkOutput("over",    ctl_mem0_over_o, eOver);
        checkOutput("allowin", ctl_mem0_allowin_o, eAllow);
        checkOutput("dest",    ctl_mem0_dest_o, mValid ? rd : 5'd0);
        checkOutput("pc",      ctl_mem0_pc_o, pc);
        checkOutput("fwd",     forward_mem02id_data_o, addr);
        checkOutput("wr",      data_wr_o, st);
        checkOutput("size",    data_size_o, szn);
        checkOutput("addr",    data_addr_o, addr);
        checkOutput("wstrb",   data_wstrb_o, expStrb);
        checkOutput("wdata",   data_wdata_o, expWdata);
        checkOutput("bus",     mem02mem1_bus_o,
                    {ale, ld, szn, zx, addr[1:0], addr, rd, we & ~ale, pc});
    endtask

    // Drive inputs after the falling edge, then check the settled outputs.
    task automatic applyStimulus(input logic exOver, input logic [107:0] bus,
                                 input logic mem1Allow, input logic addrOk);
        @(negedge clk_i);
        ctl_ex_over_i      = exOver;
        ex2mem0_bus_i      = bus;
        ctl_mem1_allowin_i = mem1Allow;
        data_addr_ok_i     = addrOk;
        #1;
        checkCycle();
    endtask

    // Advance the model across the rising edge using this cycle's inputs.
    task automatic tickClock();
        logic cap, lv;
        @(posedge clk_i);
        cycleNum++;
        cap = ctl_ex_over_i & eAllow;
        lv  = eOver & ctl_mem1_allowin_i;
        if (cap) begin
            mBus      = ex2mem0_bus_i;
            mValid    = 1'b1;
            mAccepted = 1'b0;
        end else if (lv) begin
            mValid    = 1'b0;
            mAccepted = 1'b0;
        end else if (eReq & data_addr_ok_i) begin
            mAccepted = 1'b1;
        end
    endtask

    task automatic doReset();
        rst_n_i        = 1'b0;
        ctl_ex_over_i  = 1'b0;
        data_addr_ok_i = 1'b0;
        #1;
        checkOutput("rst_req",     data_req_o, 1'b0);
        checkOutput("rst_over",    ctl_mem0_over_o, 1'b0);
        checkOutput("rst_dest",    ctl_mem0_dest_o, 5'd0);
        checkOutput("rst_allowin", ctl_mem0_allowin_o, 1'b1);
        checkOutput("rst_bus",     mem02mem1_bus_o, 77'd0);
        mValid    = 1'b0;
        mAccepted = 1'b0;
        mBus      = '0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [107:0] aluBus;
        aluBus = mkBus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h55, 5'd7, 1'b1, 32'h200);

        rst_n_i            = 1'b0;
        ex2mem0_bus_i      = '0;
        ctl_ex_over_i      = 1'b0;
        ctl_mem1_allowin_i = 1'b1;
        data_addr_ok_i     = 1'b0;
        mValid    = 1'b0;
        mAccepted = 1'b0;
        mBus      = '0;
        eOver = 1'b0; eAllow = 1'b1; eReq = 1'b0;
        #2;
        doReset();

        // word store accepted immediately
        applyStimulus(1'b1, mkBus(1'b0, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h1000,
                                  5'd3, 1'b0, 32'h100), 1'b1, 1'b0);
        tickClock();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("t1_req",   data_req_o, 1'b1);
        checkOutput("t1_wr",    data_wr_o, 1'b1);
        checkOutput("t1_wstrb", data_wstrb_o, 4'b1111);
        checkOutput("t1_wdata", data_wdata_o, 32'hDEADBEEF);
        checkOutput("t1_over",  ctl_mem0_over_o, 1'b1);
        tickClock();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t1_after_req", data_req_o, 1'b0);
        tickClock();

        // byte store, addr_ok delayed three cycles
        applyStimulus(1'b1, mkBus(1'b0, 1'b1, 2'b00, 1'b0, 32'h000000A5, 32'h1003,
                                  5'd5, 1'b0, 32'h104), 1'b1, 1'b0);
        tickClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, aluBus, 1'b1, 1'b0);
            checkOutput("t2_req",     data_req_o, 1'b1);
            checkOutput("t2_allowin", ctl_mem0_allowin_o, 1'b0);
            checkOutput("t2_wstrb",   data_wstrb_o, 4'b1000);
            checkOutput("t2_wdata",   data_wdata_o, 32'hA5A5A5A5);
            tickClock();
        end
        applyStimulus(1'b1, aluBus, 1'b1, 1'b1);
        checkOutput("t2_accept_over",    ctl_mem0_over_o, 1'b1);
        checkOutput("t2_accept_allowin", ctl_mem0_allowin_o, 1'b1);
        tickClock();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t2_alu_req",  data_req_o, 1'b0);
        checkOutput("t2_alu_over", ctl_mem0_over_o, 1'b1);
        tickClock();

        // half load held by mem1 for two cycles
        applyStimulus(1'b1, mkBus(1'b1, 1'b0, 2'b01, 1'b1, 32'h0, 32'h2002,
                                  5'd9, 1'b1, 32'h108), 1'b1, 1'b0);
        tickClock();
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("t3_req",  data_req_o, 1'b1);
        checkOutput("t3_over", ctl_mem0_over_o, 1'b1);
        tickClock();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            checkOutput("t3_held_req",  data_req_o, 1'b0);
            checkOutput("t3_held_over", ctl_mem0_over_o, 1'b1);
            checkOutput("t3_addr_lo",   mem02mem1_bus_o[71:70], 2'b10);
            checkOutput("t3_zext",      mem02mem1_bus_o[72], 1'b1);
            checkOutput("t3_size",      mem02mem1_bus_o[74:73], 2'b01);
            tickClock();
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tickClock();

        // ALU op then word load back to back
        applyStimulus(1'b1, aluBus, 1'b1, 1'b0);
        tickClock();
        applyStimulus(1'b1, mkBus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h4000,
                                  5'd12, 1'b1, 32'h10C), 1'b1, 1'b1);
        checkOutput("t4_alu_req",     data_req_o, 1'b0);
        checkOutput("t4_alu_allowin", ctl_mem0_allowin_o, 1'b1);
        checkOutput("t4_alu_dest",    ctl_mem0_dest_o, 5'd7);
        tickClock();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("t4_ld_req",  data_req_o, 1'b1);
        checkOutput("t4_ld_dest", ctl_mem0_dest_o, 5'd12);
        tickClock();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t4_empty_dest", ctl_mem0_dest_o, 5'd0);
        tickClock();

        // reset in the middle of a request
        applyStimulus(1'b1, mkBus(1'b0, 1'b1, 2'b10, 1'b0, 32'h12345678, 32'h5000,
                                  5'd2, 1'b0, 32'h110), 1'b1, 1'b0);
        tickClock();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("t5_req_before", data_req_o, 1'b1);
        doReset();
        applyStimulus(1'b1, mkBus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h6001,
                                  5'd8, 1'b1, 32'h114), 1'b1, 1'b0);
        tickClock();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("t5_req_after", data_req_o, 1'b1);
        tickClock();

        // misaligned word load
        applyStimulus(1'b1, mkBus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h3002,
                                  5'd4, 1'b1, 32'h118), 1'b1, 1'b0);
        tickClock();
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
`ifdef MEM0_ALIGN_CHECK_EN
        checkOutput("t6_req",  data_req_o, 1'b0);
        checkOutput("t6_ale",  mem02mem1_bus_o[76], 1'b1);
        checkOutput("t6_we",   mem02mem1_bus_o[32], 1'b0);
        checkOutput("t6_over", ctl_mem0_over_o, 1'b1);
`else
        checkOutput("t6_req",  data_req_o, 1'b1);
        checkOutput("t6_ale",  mem02mem1_bus_o[76], 1'b0);
`endif
        tickClock();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int op;
            logic [107:0] b;
            op = int'($urandom_range(0, 2));
            b = mkBus(op == 1, op == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), $urandom);
            applyStimulus($urandom_range(0, 9) < 7, b,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
            tickClock();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mem0_stage.md
# mem0_stage

First memory pipeline stage, directly downstream of the execute stage. Latches the execute-to-mem0 bus, turns load/store information into a single data-memory address-phase request (size, byte strobes, replicated store data), and holds the instruction until the memory accepts the address. Then forwards a compact bus to mem1, where load data is returned and extended. Non-memory instructions pass through in one cycle.

## Interface
- `EX2MEM0BusSize`, from common.vh (108): input bus width.
- `MEM02MEM1BusSize`, from common.vh (77): output bus width.
- Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- ex2mem0_bus_i  in  108  {mem_ctl[5:0], st_data[31:0], ex_result[31:0], rd_addr[4:0], rd_we, pc[31:0]}
- ctl_ex_over_i  in  1  EX holds a finished instruction
- ctl_mem0_allowin_o  out  1  mem0 can accept this cycle
- ctl_mem1_allowin_i  in  1  mem1 can accept this cycle
- ctl_mem0_over_o  out  1  mem0 instruction done, may advance
- mem02mem1_bus_o  out  77  {ale, load, size[1:0], zext, addr_lo[1:0], result[31:0], rd_addr[4:0], rd_we, pc[31:0]}
- ctl_mem0_dest_o  out  5  rd_addr gated by valid
- ctl_mem0_pc_o  out  32  latched pc
- forward_mem02id_data_o  out  32  latched ex_result
- data_req_o  out  1  address-phase request
- data_wr_o  out  1  1 = store
- data_size_o  out  2  00 byte, 01 half, 10 word
- data_addr_o  out  32  ex_result
- data_wstrb_o  out  4  byte strobes; 0000 on loads
- data_wdata_o  out  32  replicated store data
- data_addr_ok_i  in  1  memory accepts address this cycle

## Operation
- mem_ctl fields: bit5 load, bit4 store, [3:2] size, bit1 zext, bit0 ignored. memop = load | store. load and store are never both 1.
- Pipeline register captures bus at clock edge when ctl_ex_over_i & ctl_mem0_allowin_o. valid_q is set on capture and cleared when the instruction leaves without a new capture.
- FSM states:
  - IDLE: empty or non-memop.
  - REQ: data_req_o=1.
  - HELD: address accepted, waiting for mem1.
- Capture of a memop goes to REQ; any other capture goes to IDLE.
- REQ & data_addr_ok_i & ctl_mem1_allowin_i: capture next (REQ/IDLE) or IDLE.
- REQ & data_addr_ok_i & ~ctl_mem1_allowin_i: HELD.
- HELD & ctl_mem1_allowin_i: capture next or IDLE.
- data_req_o is asserted only in REQ. A request is never reissued after addr_ok.
- ctl_mem0_over_o = valid_q & (~memop | (REQ & data_addr_ok_i) | HELD).
- ctl_mem0_allowin_o = ~valid_q | (ctl_mem0_over_o & ctl_mem1_allowin_i).
- Byte strobes:
  - byte: 0001<<addr[1:0].
  - half: 0011<<{addr[1],0}.
  - word: 1111.
- Store data:
  - byte: {4{st[7:0]}}.
  - half: {2{st[15:0]}}.
  - word: st.
- Size 11 is treated as word.
- result = ex_result. addr_lo = ex_result[1:0].
- ctl_mem0_dest_o = rd_addr & {5{valid_q}}.

## Timing
- Reset (asynchronous, immediate):
  - valid_q=0 and state IDLE.
  - Latched bus = 0, so all bus-derived outputs are 0.
  - data_req_o=0 and ctl_mem0_over_o=0.
  - ctl_mem0_allowin_o=1.
- Reset during REQ drops the request in the same cycle. The memory side tolerates this.
- Latency from capture edge N:
  - Request is visible in cycle N.
  - addr_ok in cycle N gives over in cycle N and handoff at edge N+1. This is zero-bubble back-to-back.
- Each cycle of addr_ok=0 adds one cycle of stall. Address, strobes and data stay stable while data_req_o=1.
- Non-memop: over in the capture cycle; no request.
- addr_ok seen outside REQ is ignored.
- The ale bit is 0 unless the feature below is compiled in.

## Configuration
- MEM0_ALIGN_CHECK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, sets ale=1.
  - It issues no request, takes no REQ state, and goes over immediately like a non-memop.
  - rd_we is forced to 0 in the output bus.
- MEM0_ALIGN_CHECK_EN undefined:
  - ale is tied 0 and the request is always issued.
  - Strobes follow the rules above; the misaligned low bit is dropped.

## Test plan
- Word store, st_data=0xDEADBEEF, addr=0x1000, addr_ok in same cycle -> req for 1 cycle, wr=1, wstrb=1111, wdata=0xDEADBEEF, over same cycle, handoff next edge.
- Byte store, st_data=0x000000A5, addr=0x1003, addr_ok delayed 3 cycles -> req held 4 cycles with stable outputs, wstrb=1000, wdata=0xA5A5A5A5, allowin=0 until accept.
- Half load, zext=1, addr=0x2002, addr_ok=1, mem1_allowin=0 for 2 cycles -> single req cycle, HELD 2 cycles with req=0, bus addr_lo=10, zext=1, size=01.
- Back-to-back ALU op then word load, mem1 always ready, addr_ok=1 -> two consecutive handoffs with no bubble; ALU op never raises req; dest=rd_addr only while valid.
- Assert rst_n_i low mid-REQ -> req, over and dest drop to 0 immediately, allowin=1. After release, the next capture behaves normally.
- With MEM0_ALIGN_CHECK_EN, word load at addr=0x3002 -> no req, ale=1, rd_we=0, over in capture cycle. Without the macro -> req issued, ale=0.
